// File: rtl/sram_wb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// sram_wb_arbiter : round-robin M0 (Wishbone) / M1 (req/done) front end for
//                   the 1024x32 Wishbone SRAM, with a no-ack watchdog.
// Revision 1.0
// ------------------------------------------------------------------------
module sram_wb_arbiter #(
  parameter logic [31:0] SRAM_BASE = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] DEAD_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [9:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY0 = 3'd1,
    BUSY1 = 3'd2,
    DONE0 = 3'd3,
    DONE1 = 3'd4
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_grant;
  logic [7:0]  wd_cnt;
  logic        r0;
  logic        r1;
  logic        pick0;
  logic        finish;
  logic [31:0] done_data;

  assign r0        = m0_cyc_i & m0_stb_i;
  assign r1        = m1_req;
  // On a tie the requester that did not win last time gets the slave.
  assign pick0     = r0 & (~r1 | last_grant);
  // An ack in the final watchdog cycle still counts as a real completion.
  assign finish    = s_ack_i | (wd_cnt == WD_LAST);
  assign done_data = s_ack_i ? s_dat_i : DEAD_DATA;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wd_cnt     <= 8'd0;
      m0_dat_o   <= 32'd0;
      m0_ack_o   <= 1'b0;
      m1_rdata   <= 32'd0;
      m1_done    <= 1'b0;
      s_cyc_o    <= 1'b0;
      s_stb_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_sel_o    <= 4'd0;
      s_adr_o    <= 32'd0;
      s_dat_o    <= 32'd0;
      timeout_o  <= 1'b0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (r0 || r1) begin
            wd_cnt  <= 8'd0;
            s_cyc_o <= 1'b1;
            s_stb_o <= 1'b1;
            if (pick0) begin
              state      <= BUSY0;
              last_grant <= 1'b0;
              s_we_o     <= m0_we_i;
              s_sel_o    <= m0_sel_i;
              s_adr_o    <= m0_adr_i;
              s_dat_o    <= m0_dat_i;
            end else begin
              state      <= BUSY1;
              last_grant <= 1'b1;
              s_we_o     <= m1_we;
              s_sel_o    <= 4'hF;
              s_adr_o    <= SRAM_BASE | {20'b0, m1_addr, 2'b00};
              s_dat_o    <= m1_wdata;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (finish) begin
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            if (!s_ack_i) begin
              timeout_o <= 1'b1;
            end
            if (state == BUSY0) begin
              state <= DONE0;
              // A master that abandoned its cycle gets no ack and no data.
              if (m0_cyc_i) begin
                m0_ack_o <= 1'b1;
                m0_dat_o <= done_data;
              end
            end else begin
              state    <= DONE1;
              m1_done  <= 1'b1;
              m1_rdata <= done_data;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_wb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_sram_wb_arbiter : directed bench with a transaction-level model.
// Revision 1.0
// ------------------------------------------------------------------------
module tb_sram_wb_arbiter;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [3:0]  m0_sel_i = 4'h0;
  logic [31:0] m0_adr_i = 32'd0, m0_dat_i = 32'd0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [9:0]  m1_addr = 10'd0;
  logic [31:0] m1_wdata = 32'd0;
  logic [31:0] m1_rdata;
  logic        m1_done;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = 32'd0;
  logic        s_ack_i = 1'b0;
  logic        timeout_o;

  sram_wb_arbiter dut (
    .wb_clk_i (clk),      .wb_rst_i (wb_rst_i),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
    .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o),
    .m1_req   (m1_req),   .m1_we    (m1_we),    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata), .m1_rdata (m1_rdata), .m1_done  (m1_done),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM environment: acks on stb cycle ack_dly+1, random ack noise otherwise.
  int          ack_dly = 1;
  logic [31:0] sram [1024];
  logic [31:0] model_mem [1024];
  int          scnt = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'd0;
      model_mem[i] = 32'd0;
    end
    forever begin
      @(posedge clk); #1;
      s_ack_i = 1'b0;
      if (s_stb_o) begin
        scnt++;
        if (scnt == ack_dly + 1) begin
          if (s_we_o) sram[s_adr_o[11:2]] = merge(sram[s_adr_o[11:2]], s_dat_o, s_sel_o);
          s_dat_i = sram[s_adr_o[11:2]];
          s_ack_i = 1'b1;
        end
      end else begin
        scnt    = 0;
        s_ack_i = 1'($urandom_range(0, 1));
        s_dat_i = $urandom;
      end
    end
  end

  // Transaction-level model: expected slave accesses in grant order.
  typedef struct {
    logic        owner;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic        cur_valid = 1'b0, cur_to = 1'b0, prev_stb = 1'b0, to_exp = 1'b0;
  logic        rst_q = 1'b1;
  logic [31:0] cur_resp;
  logic [3:0]  done_log = 4'd0;
  int          cyc_n = 0, start_cyc = 0, exp_lat = 0;

  task automatic push(input logic owner, input logic we, input logic [3:0] sel,
                      input logic [31:0] adr, input logic [31:0] dat);
    txn_t t;
    t.owner = owner; t.we = we; t.sel = sel; t.adr = adr; t.dat = dat;
    exp_q.push_back(t);
  endtask

  always @(posedge clk) rst_q <= wb_rst_i;

  initial begin
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst_q) begin
        cur_valid = 1'b0;
        to_exp    = 1'b0;
      end else begin
        check("cyc_eq_stb", {31'b0, s_cyc_o}, {31'b0, s_stb_o});
        if (s_stb_o && !prev_stb) begin
          if (exp_q.size() == 0) begin
            fail_evt("unexpected_stb");
          end else begin
            cur = exp_q.pop_front();
            check("slv_adr", s_adr_o, cur.adr);
            check("slv_we",  {31'b0, s_we_o}, {31'b0, cur.we});
            check("slv_sel", {28'b0, s_sel_o}, {28'b0, cur.sel});
            check("slv_dat", s_dat_o, cur.dat);
            cur_valid = 1'b1;
            start_cyc = cyc_n;
            cur_to    = (ack_dly >= 64);
            exp_lat   = cur_to ? 64 : ack_dly + 1;
            if (cur_to) begin
              cur_resp = 32'hDEAD_BEEF;
            end else begin
              if (cur.we) model_mem[cur.adr[11:2]] = merge(model_mem[cur.adr[11:2]], cur.dat, cur.sel);
              cur_resp = model_mem[cur.adr[11:2]];
            end
          end
        end
        if (m0_ack_o || m1_done) begin
          if (!cur_valid) begin
            fail_evt("stray_done");
          end else begin
            check("done_owner", {31'b0, m1_done}, {31'b0, cur.owner});
            check("done_both", {31'b0, m0_ack_o & m1_done}, 32'd0);
            check("done_data", cur.owner ? m1_rdata : m0_dat_o, cur_resp);
            check("done_latency", cyc_n - start_cyc, exp_lat);
            check("stb_dropped", {31'b0, s_stb_o}, 32'd0);
            if (cur_to) to_exp = 1'b1;
            done_log  = {done_log[2:0], m1_done};
            cur_valid = 1'b0;
          end
        end
        check("timeout_flag", {31'b0, timeout_o}, {31'b0, to_exp});
      end
      prev_stb = rst_q ? 1'b0 : s_stb_o;
    end
  end

  task automatic m0_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rd, output int lat);
    push(1'b0, we, 4'hF, adr, dat);
    @(posedge clk); #1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we;
    m0_sel_i = 4'hF; m0_adr_i = adr; m0_dat_i = dat;
    lat = 0;
    forever begin
      @(negedge clk);
      if (m0_ack_o) break;
      lat++;
      if (lat > 300) begin fail_evt("m0_wait_expired"); break; end
    end
    rd = m0_dat_o;
    @(posedge clk); #1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);
    check("m0_ack_single", {31'b0, m0_ack_o}, 32'd0);
  endtask

  task automatic m1_xfer(input logic we, input logic [9:0] addr, input logic [31:0] dat,
                         output logic [31:0] rd, output int lat);
    push(1'b1, we, 4'hF, 32'h3000_0000 + 32'(addr) * 4, dat);
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = dat;
    lat = 0;
    forever begin
      @(negedge clk);
      if (m1_done) break;
      lat++;
      if (lat > 300) begin fail_evt("m1_wait_expired"); break; end
    end
    rd = m1_rdata;
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    check("m1_done_single", {31'b0, m1_done}, 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat, seen, n0, n1;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc",   {31'b0, s_cyc_o}, 32'd0);
    check("rst_stb",   {31'b0, s_stb_o}, 32'd0);
    check("rst_ack",   {31'b0, m0_ack_o}, 32'd0);
    check("rst_done",  {31'b0, m1_done}, 32'd0);
    check("rst_to",    {31'b0, timeout_o}, 32'd0);
    check("rst_m0dat", m0_dat_o, 32'd0);
    check("rst_m1dat", m1_rdata, 32'd0);
    check("rst_adr",   s_adr_o, 32'd0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;

    ack_dly = 1;
    m0_xfer(1'b1, 32'h3000_0010, 32'hA5A5_0001, rd, lat);
    check("m0_wr_latency", lat, 3);
    check("m0_wr_adr", s_adr_o, 32'h3000_0010);
    m0_xfer(1'b0, 32'h3000_0010, 32'd0, rd, lat);
    check("m0_rd_data", rd, 32'hA5A5_0001);

    m1_xfer(1'b1, 10'h3FF, 32'h1234_5678, rd, lat);
    check("m1_wr_adr", s_adr_o, 32'h3000_0FFC);
    check("m1_wr_sel", {28'b0, s_sel_o}, 32'hF);
    m0_xfer(1'b0, 32'h3000_0FFC, 32'd0, rd, lat);
    check("m0_rd_m1_data", rd, 32'h1234_5678);

    // Both requesters held high for two transactions each.
    do_reset(1);
    push(1'b0, 1'b1, 4'hF, 32'h3000_0020, 32'h1111_0000);
    push(1'b1, 1'b0, 4'hF, 32'h3000_0FFC, 32'd0);
    push(1'b0, 1'b1, 4'hF, 32'h3000_0024, 32'h2222_0000);
    push(1'b1, 1'b0, 4'hF, 32'h3000_0020, 32'd0);
    @(posedge clk); #1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_sel_i = 4'hF;
    m0_adr_i = 32'h3000_0020; m0_dat_i = 32'h1111_0000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h3FF; m1_wdata = 32'd0;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          n0 = 0;
          do begin @(negedge clk); n0++; end while (!m0_ack_o && n0 < 400);
          if (!m0_ack_o) fail_evt("rr_m0_wait_expired");
          @(posedge clk); #1;
          if (i == 0) begin m0_adr_i = 32'h3000_0024; m0_dat_i = 32'h2222_0000; end
          else begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
        end
      end
      begin
        for (int j = 0; j < 2; j++) begin
          n1 = 0;
          do begin @(negedge clk); n1++; end while (!m1_done && n1 < 400);
          if (!m1_done) fail_evt("rr_m1_wait_expired");
          @(posedge clk); #1;
          if (j == 0) m1_addr = 10'd8;
          else m1_req = 1'b0;
        end
      end
    join
    @(negedge clk);
    check("rr_order", {28'b0, done_log}, 32'h5);
    check("rr_m0_last", m0_dat_o, 32'h2222_0000);
    check("rr_m1_last", m1_rdata, 32'h1111_0000);

    // Slave never acks: watchdog completes with dead data.
    ack_dly = 1000;
    m0_xfer(1'b0, 32'h3000_0010, 32'd0, rd, lat);
    check("to_data", rd, 32'hDEAD_BEEF);
    check("to_latency", lat, 65);
    check("to_flag", {31'b0, timeout_o}, 32'd1);
    ack_dly = 1;
    m1_xfer(1'b0, 10'h3FF, 32'd0, rd, lat);
    check("to_after_data", rd, 32'h1234_5678);
    check("to_sticky", {31'b0, timeout_o}, 32'd1);

    // Ack arriving in the last watchdog cycle wins.
    do_reset(2);
    @(negedge clk);
    check("to_cleared", {31'b0, timeout_o}, 32'd0);
    ack_dly = 63;
    m0_xfer(1'b0, 32'h3000_0010, 32'd0, rd, lat);
    check("edge_data", rd, 32'hA5A5_0001);
    check("edge_latency", lat, 65);
    check("edge_no_to", {31'b0, timeout_o}, 32'd0);

    // Reset in the middle of an M1 access.
    ack_dly = 1000;
    push(1'b1, 1'b0, 4'hF, 32'h3000_0014, 32'd0);
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd5; m1_wdata = 32'd0;
    repeat (5) @(posedge clk);
    #1;
    wb_rst_i = 1'b1; m1_req = 1'b0;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc", {31'b0, s_cyc_o}, 32'd0);
    check("rst_mid_stb", {31'b0, s_stb_o}, 32'd0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (m1_done) seen++; end
    check("rst_mid_no_done", seen, 0);
    ack_dly = 1;
    m1_xfer(1'b0, 10'h3FF, 32'd0, rd, lat);
    check("rst_mid_fresh", rd, 32'h1234_5678);
    check("rst_mid_fresh_lat", lat, 3);

    repeat (3) @(negedge clk);
    check("model_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_wb_arbiter.md
Name: sram_wb_arbiter

Overview:
- Two-requester arbiter in front of the 1024x32 Wishbone SRAM macro in the user project area.
- Requester 0 (M0) is the Caravel management Wishbone port. Requester 1 (M1) is a simple req/done word port driven from user logic or LA pins.
- Round-robin grant. Slave-side outputs are registered. A watchdog terminates transactions the SRAM never acks.

Parameters:
- SRAM_BASE, 32'h3000_0000: base byte address placed on s_adr_o for M1 accesses.
- TIMEOUT, 64: cycles in BUSY without s_ack_i before forced termination; legal range 2..255.
- DEAD_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- m0_cyc_i  in  1  M0 cycle
- m0_stb_i  in  1  M0 strobe
- m0_we_i  in  1  M0 write enable
- m0_sel_i  in  4  M0 byte selects
- m0_adr_i  in  32  M0 byte address
- m0_dat_i  in  32  M0 write data
- m0_dat_o  out  32  M0 read data
- m0_ack_o  out  1  M0 acknowledge
- m1_req  in  1  M1 request, level
- m1_we  in  1  M1 write enable
- m1_addr  in  10  M1 word address
- m1_wdata  in  32  M1 write data
- m1_rdata  out  32  M1 read data
- m1_done  out  1  M1 completion pulse
- s_cyc_o  out  1  SRAM cycle
- s_stb_o  out  1  SRAM strobe
- s_we_o  out  1  SRAM write enable
- s_sel_o  out  4  SRAM byte selects
- s_adr_o  out  32  SRAM byte address
- s_dat_o  out  32  SRAM write data
- s_dat_i  in  32  SRAM read data
- s_ack_i  in  1  SRAM acknowledge
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: all outputs 0, FSM=IDLE, last_grant=1 (M0 wins the first tie), watchdog counter=0. Reset applies from any state. If asserted mid-transaction, s_cyc_o/s_stb_o are low after that edge and no ack/done is issued.
- Request terms: r0 = m0_cyc_i & m0_stb_i; r1 = m1_req.
- FSM states: IDLE, BUSY0, BUSY1, DONE0, DONE1.
- IDLE:
  - Only r0 -> BUSY0. Only r1 -> BUSY1.
  - Both -> grant the requester not equal to last_grant; last_grant updates on grant.
  - On grant, latch we/sel/adr/dat into the slave-side registers. M0 fields are passed through. M1 uses s_adr_o = SRAM_BASE | {20'b0, m1_addr, 2'b00} and s_sel_o = 4'hF.
- BUSY0/BUSY1:
  - s_cyc_o = s_stb_o = 1; slave-side fields held stable.
  - Watchdog increments each cycle.
  - s_ack_i=1: capture s_dat_i, drop cyc/stb at the next edge, go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: drop cyc/stb, capture DEAD_DATA, set timeout_o, go to DONE.
  - s_ack_i and timeout in the same cycle: ack wins, timeout_o is not set.
- DONE0: m0_ack_o=1 for exactly one cycle, with m0_dat_o valid, only if m0_cyc_i=1; otherwise the result is discarded silently. Next state IDLE.
- DONE1: m1_done=1 for exactly one cycle; m1_rdata is updated. Next state IDLE.
- Data hold: m0_dat_o and m1_rdata hold their last captured value until the next completion for that requester. Writes also update them with the captured s_dat_i.
- Latency: request seen in IDLE at cycle T -> s_stb_o at T+1 -> slave ack at T+1+k -> m0_ack_o/m1_done at T+2+k. Minimum 3 cycles request-to-ack.
- Back-to-back: after DONE the FSM passes through IDLE, so there is at least one idle cycle on the slave bus between transactions.
- Handshake rules:
  - m1_req must stay high until m1_done; m1 fields must stay stable while m1_req is high.
  - Dropping m0_stb_i/m0_cyc_i during BUSY0 does not abort the slave transaction.
  - s_ack_i outside BUSY states is ignored.
- timeout_o clears only on reset.

Test Plan:
- Single M0 write adr=32'h3000_0010, dat=32'hA5A5_0001, sel=4'hF, SRAM acks 1 cycle after stb -> s_adr_o=32'h3000_0010; m0_ack_o pulses once at request+3. Then an M0 read of the same address -> m0_dat_o=32'hA5A5_0001.
- M1 write addr=10'h3FF, data=32'h1234_5678, then M0 read 32'h3000_0FFC -> s_adr_o=32'h3000_0FFC, s_sel_o=4'hF on the M1 access; the M0 read returns 32'h1234_5678.
- r0 and r1 asserted continuously for 4 transactions after reset -> grant order M0, M1, M0, M1; at least one idle cycle between slave strobes.
- s_ack_i tied low, M0 read -> cyc/stb drop after exactly 64 BUSY cycles; m0_ack_o pulses with m0_dat_o=32'hDEAD_BEEF; timeout_o=1 and stays 1 through later good transactions until reset.
- s_ack_i asserted on BUSY cycle 64 (same cycle as timeout) -> real data returned, timeout_o=0.
- wb_rst_i asserted for 1 cycle mid-BUSY1 -> s_cyc_o=0 next cycle, m1_done never pulses; a fresh M1 request afterwards completes normally.
